serial_add_ctrl: RTL and testbench

Bit-serial addition sequencer that time-shares one external 1-bit full_adder cell to add two WIDTH-bit operands. On start it latches the operands and carry-in, then steps the cell LSB-first for WIDTH cycles, registering each sum bit and the ripple carry. It presents the WIDTH-bit result, carry-out and a one-cycle done pulse. It sits between a requester (bench or upper control) and the full_adder datapath cell, which is instantiated beside it and wired through the fa_* ports.

---
 rtl/serial_add_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial addition sequencer. A single external 1-bit full_adder cell is
// time-shared to add two WIDTH-bit operands, LSB first, one bit per cycle.
//
// Operation:
//   IDLE : waits for start; on an accepted start the operands and carry-in
//          are captured into internal shift registers.
//   ADD  : WIDTH cycles. Each cycle presents the current LSBs and the ripple
//          carry to the full_adder, shifts the returned sum bit in at the
//          MSB of the partial-sum register and registers the new carry.
//   DONE : one cycle; done is high, then back to IDLE unconditionally.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only in IDLE
//   a, b      in   WIDTH-bit operands, captured with an accepted start
//   cin       in   carry-in, captured with an accepted start
//   fa_a      out  operand-A bit to the full_adder
//   fa_b      out  operand-B bit to the full_adder
//   fa_cin    out  ripple carry to the full_adder
//   fa_sum    in   full_adder sum (combinational from fa_*)
//   fa_carry  in   full_adder carry (combinational from fa_*)
//   busy      out  high while in ADD
//   done      out  one-cycle completion pulse
//   sum       out  registered result, held until the next completion
//   cout      out  registered carry-out, held until the next completion
//
// Result: {cout, sum} = a + b + cin modulo 2^(WIDTH+1).
// Inputs start/a/b/cin reach outputs only through registers.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter width leaves headroom so WIDTH-1 is always representable.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic [WIDTH-1:0] sum_nx_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             last_s;

  // Final ADD cycle: this edge both retires the last bit and leaves ADD.
  assign last_s = (cnt_r == CNT_LAST);

  // Next state of the sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = ADD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = ADD;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Partial sum shifted right with the fresh sum bit entering at the MSB.
  // Written as shift-then-overwrite so WIDTH=1 needs no zero-width slice.
  always_comb begin
    sum_nx_s = sum_sr_r >> 1;
    sum_nx_s[WIDTH-1] = fa_sum;
  end

  // Full-adder drive: only meaningful in ADD, held at zero otherwise.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_r == ADD) begin
      fa_a   = a_sr_r[0];
      fa_b   = b_sr_r[0];
      fa_cin = carry_r;
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, bit-serial shifting, carry ripple and result publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      sum_sr_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            carry_r  <= cin;
            cnt_r    <= '0;
            sum_sr_r <= '0;
          end
        end
        ADD: begin
          sum_sr_r <= sum_nx_s;
          carry_r  <= fa_carry;
          a_sr_r   <= a_sr_r >> 1;
          b_sr_r   <= b_sr_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          // Result registers move only on the final ADD edge, so a reset
          // mid-operation never exposes a partial sum.
          if (last_s) begin
            sum_r  <= sum_nx_s;
            cout_r <= fa_carry;
          end
        end
        DONE: begin
          // Nothing to update; result already published on the ADD exit edge.
        end
        default: begin
          // Unreachable encoding: state logic steers back to IDLE.
        end
      endcase
    end
  end

  assign busy = (state_r == ADD);
  assign done = (state_r == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl. Two instances: WIDTH=8 (main) and
// WIDTH=1 (degenerate case). Each instance is wired to its own behavioural
// full adder built from continuous assigns. Inputs are driven and outputs
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // WIDTH=8 instance signals
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_carry;
  logic       busy, done, cout;
  logic [7:0] sum;

  // WIDTH=1 instance signals
  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_carry1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural full-adder cells
  assign fa_sum    = fa_a ^ fa_b ^ fa_cin;
  assign fa_carry  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_sum1   = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_carry1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_carry(fa_carry),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
    .fa_sum(fa_sum1), .fa_carry(fa_carry1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation: pulse start, wait (bounded) for done, check result.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input string tag);
    logic [8:0] exp;
    int n;
    exp = {1'b0, x} + {1'b0, y} + {8'h00, c};
    a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_sum"}, sum, exp[7:0]);
    chk({tag, "_cout"}, cout, exp[8]);
    tick();
  endtask

  initial begin
    logic [7:0] x5a;
    logic [8:0] e9;
    logic [1:0] e2;
    int n;
    int bad;
    x5a = 8'h5A;

    // ---------------- reset state ----------------
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_fa_a", fa_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // ---------------- test 1: 0x5A + 0x3C ----------------
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;   // post-capture changes must not matter
    for (int i = 0; i < 8; i++) begin
      chk("t1_busy", busy, 1);
      chk("t1_done_low", done, 0);
      chk("t1_fa_a", fa_a, x5a[i]);
      chk("t1_sum_held", sum, 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
    chk("t1_fa_zero", {fa_a, fa_b, fa_cin}, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // ---------------- test 2: carries and hold ----------------
    op8(8'hFF, 8'h01, 1'b0, "t2a");
    for (int i = 0; i < 3; i++) tick();
    chk("t2_hold_sum", sum, 8'h00);
    chk("t2_hold_cout", cout, 1);
    op8(8'hFF, 8'hFF, 1'b1, "t2b");
    chk("t2b_sum_after", sum, 8'hFF);

    // ---------------- test 3: start held, operands change ----------------
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();          // E0 accepted
    tick();
    tick();
    a = 8'h01; b = 8'h01;
    n = 0;
    while (done !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t3_first_sum", sum, 8'h30);
    n = 0;
    tick(); n++;
    while (done !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t3_done_spacing", n, 10);
    chk("t3_second_sum", sum, 8'h02);
    start = 1'b0;
    tick();

    // ---------------- test 4: reset mid-operation ----------------
    op8(8'h0F, 8'h01, 1'b0, "t4a");
    a = 8'h33; b = 8'h11; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();   // now in 4th ADD cycle
    chk("t4_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_sum", sum, 0);
    chk("t4_rst_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    chk("t4_no_done_after_rst", bad, 0);
    op8(8'h33, 8'h11, 1'b1, "t4b");

    // ---------------- test 5: WIDTH=1 truth table ----------------
    for (int k = 0; k < 8; k++) begin
      a1 = k[2]; b1 = k[1]; cin1 = k[0]; start1 = 1'b1;
      e2 = {1'b0, k[2]} + {1'b0, k[1]} + {1'b0, k[0]};
      tick();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_done_early", done1, 0);
      tick();
      chk("w1_done", done1, 1);
      chk("w1_sum", sum1, e2[0]);
      chk("w1_cout", cout1, e2[1]);
      tick();
    end

    // ---------------- test 6: random operations ----------------
    for (int k = 0; k < 200; k++) begin
      logic [7:0] rx, ry;
      logic rc;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      e9 = {1'b0, rx} + {1'b0, ry} + {8'h00, rc};
      op8(rx, ry, rc, "rnd");
      chk("rnd_total", {cout, sum}, e9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
